// File: rtl/score_sched_pkg.sv
// Shared constants and stage-B record for the score scheduler.
package score_sched_pkg;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           clr;
        logic [W-1:0]   opa;
        logic [W-1:0]   delta;
        logic           vld;
    } stage_b_t;

endpackage

// File: rtl/cla_add16.sv
// 16-bit carry-lookahead adder: 4-bit groups with group-level lookahead.
module cla_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gg = '0;
        gp = '0;
        gc = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        c[16] = gc[4];
        sum   = p ^ c[15:0];
        cout  = c[16];
    end

endmodule

// File: rtl/sched_rr_arb.sv
// Round-robin one-hot arbiter; search starts at the pointer register.
module sched_rr_arb
    import score_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            gnt_any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        if (gnt_any) gnt[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

endmodule

// File: rtl/score_sched.sv
// Round-robin shared-adder score scheduler, two-stage with forwarding.
// SCORE_SAT_EN: saturate to all-ones on carry-out instead of wrapping.
module score_sched
    import score_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_clr,
    input  logic [NREQ*W-1:0] req_delta,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ*W-1:0] score,
    output logic [NREQ-1:0]   ovf,
    output logic              upd_valid,
    output logic [IDW-1:0]    upd_id
);

    logic [W-1:0]    score_q [NREQ];
    logic [NREQ-1:0] ovf_q;
    stage_b_t        b_q;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic [W-1:0]    sum;
    logic            cout;
    logic [W-1:0]    res;
    logic [W-1:0]    opa;

    sched_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .gnt     (req_ready),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    cla_add16 u_add (
        .a    (b_q.opa),
        .b    (b_q.delta),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        res = '0;
`ifdef SCORE_SAT_EN
        if (!b_q.clr) res = cout ? '1 : sum;
`else
        if (!b_q.clr) res = sum;
`endif
        // stage-B result bypasses the register it is about to overwrite
        opa = (b_q.vld && b_q.id == gnt_id) ? res : score_q[gnt_id];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) score_q[i] <= '0;
            ovf_q     <= '0;
            b_q       <= '0;
            upd_valid <= 1'b0;
            upd_id    <= '0;
        end else begin
            b_q.id    <= gnt_id;
            b_q.clr   <= req_clr[gnt_id];
            b_q.opa   <= opa;
            b_q.delta <= req_delta[gnt_id*W +: W];
            b_q.vld   <= gnt_any;
            upd_valid <= b_q.vld;
            upd_id    <= b_q.id;
            if (b_q.vld) begin
                score_q[b_q.id] <= res;
                ovf_q[b_q.id]   <= ~b_q.clr & (ovf_q[b_q.id] | cout);
            end
        end
    end

    always_comb begin
        score = '0;
        for (int i = 0; i < NREQ; i++) score[i*W +: W] = score_q[i];
        ovf = ovf_q;
    end

endmodule

// File: tb/tb_score_sched.sv
// Directed bench for score_sched: reset, add, round-robin, forwarding, overflow.
module tb_score_sched;
    import score_sched_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_clr;
    logic [NREQ*W-1:0] req_delta;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] score;
    logic [NREQ-1:0]   ovf;
    logic              upd_valid;
    logic [IDW-1:0]    upd_id;

    int total = 0;
    int bad   = 0;

    logic [NREQ-1:0] exp_g  [8] = '{4'h2, 4'h4, 4'h8, 4'h1,
                                    4'h2, 4'h4, 4'h8, 4'h1};
    logic [IDW-1:0]  exp_id [8] = '{2'd1, 2'd2, 2'd3, 2'd0,
                                    2'd1, 2'd2, 2'd3, 2'd0};
    logic [W-1:0]    exp_ovfl;
    logic [W-1:0]    exp_after;

    score_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_clr   (req_clr),
        .req_delta (req_delta),
        .req_ready (req_ready),
        .score     (score),
        .ovf       (ovf),
        .upd_valid (upd_valid),
        .upd_id    (upd_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] sc(input int i);
        return score[i*W +: W];
    endfunction

    task automatic set_req(input int i, input logic c,
                           input logic [W-1:0] d);
        req_valid[i]       = 1'b1;
        req_clr[i]         = c;
        req_delta[i*W +: W] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_clr   = '0;
    endtask

    initial begin
`ifdef SCORE_SAT_EN
        exp_ovfl  = 16'hFFFF;
        exp_after = 16'hFFFF;
`else
        exp_ovfl  = 16'h0010;
        exp_after = 16'h0011;
`endif
        rst_n     = 1'b0;
        req_valid = '0;
        req_clr   = '0;
        req_delta = '0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) chk("rst_score", 32'(sc(i)), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_upd_valid", 32'(upd_valid), 0);
        chk("rst_ready", 32'(req_ready), 0);
        rst_n = 1'b1;

        // single add on requester 0
        @(negedge clk);
        set_req(0, 1'b0, 16'd5);
        #1 chk("add_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        idle();
        chk("add_upd_early", 32'(upd_valid), 0);
        chk("add_score_early", 32'(sc(0)), 0);
        @(negedge clk);
        chk("add_upd_valid", 32'(upd_valid), 1);
        chk("add_upd_id", 32'(upd_id), 0);
        chk("add_score0", 32'(sc(0)), 5);
        @(negedge clk);
        chk("add_upd_drop", 32'(upd_valid), 0);

        // round-robin, pointer now at 1
        for (int i = 0; i < NREQ; i++) req_delta[i*W +: W] = 16'd1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = '1;
            #1 chk("rr_grant", 32'(req_ready), 32'(exp_g[k]));
            if (k >= 2) chk("rr_upd_id", 32'(upd_id), 32'(exp_id[k-2]));
        end
        @(negedge clk);
        idle();
        chk("rr_upd_id6", 32'(upd_id), 32'(exp_id[6]));
        @(negedge clk);
        chk("rr_upd_id7", 32'(upd_id), 32'(exp_id[7]));
        @(negedge clk);
        chk("rr_upd_done", 32'(upd_valid), 0);
        chk("rr_score0", 32'(sc(0)), 7);
        chk("rr_score1", 32'(sc(1)), 2);
        chk("rr_score2", 32'(sc(2)), 2);
        chk("rr_score3", 32'(sc(3)), 2);

        // clear requester 2, then back-to-back adds with forwarding
        @(negedge clk);
        set_req(2, 1'b1, 16'd0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("clr_score2", 32'(sc(2)), 0);
        chk("clr_upd_id", 32'(upd_id), 2);
        set_req(2, 1'b0, 16'd7);
        #1 chk("fwd_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        @(negedge clk);
        chk("fwd_score_7", 32'(sc(2)), 7);
        @(negedge clk);
        idle();
        chk("fwd_score_14", 32'(sc(2)), 14);
        @(negedge clk);
        chk("fwd_score_21", 32'(sc(2)), 21);
        @(negedge clk);
        chk("fwd_hold", 32'(sc(2)), 21);

        // overflow on requester 1
        @(negedge clk);
        set_req(1, 1'b1, 16'd0);
        @(negedge clk);
        set_req(1, 1'b0, 16'hFFF0);
        @(negedge clk);
        set_req(1, 1'b0, 16'h0020);
        chk("ovf_clr", 32'(sc(1)), 0);
        @(negedge clk);
        set_req(1, 1'b0, 16'h0001);
        chk("ovf_pre", 32'(sc(1)), 32'hFFF0);
        chk("ovf_pre_flag", 32'(ovf[1]), 0);
        @(negedge clk);
        idle();
        chk("ovf_wrap", 32'(sc(1)), 32'(exp_ovfl));
        chk("ovf_flag", 32'(ovf[1]), 1);
        @(negedge clk);
        chk("ovf_after", 32'(sc(1)), 32'(exp_after));
        chk("ovf_sticky", 32'(ovf), 32'h2);
        @(negedge clk);
        set_req(1, 1'b1, 16'd0);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("ovf_clr_score", 32'(sc(1)), 0);
        chk("ovf_clr_flag", 32'(ovf[1]), 0);

        // reset while an update sits in stage B
        @(negedge clk);
        set_req(3, 1'b0, 16'd9);
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1 chk("midrst_upd", 32'(upd_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_score3", 32'(sc(3)), 0);
        chk("midrst_upd_after", 32'(upd_valid), 0);
        chk("midrst_all", 32'(score[31:0] | score[63:32]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
